pc_fetch_unit: RTL

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

---
 rtl/pc_fetch_unit_if.sv | 25 ++
 rtl/pc_fetch_unit.sv | 104 ++++++++++
 2 files changed

// File: rtl/pc_fetch_unit_if.sv
// Fetch-stage bundle: redirect inputs, instruction-memory request/response and
// the decode-side valid/ready buffer. The fetch unit takes the master side.
interface pc_fetch_unit_if;
  logic        PCsrc;
  logic [31:0] pc_target;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  modport master (
    input  PCsrc, pc_target, imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready,
    output imem_req_valid, imem_addr, if_valid, if_pc, if_instr
  );

  modport slave (
    output PCsrc, pc_target, imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready,
    input  imem_req_valid, imem_addr, if_valid, if_pc, if_instr
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// Instruction fetch unit: one outstanding memory request, one-entry output
// buffer toward decode, and redirect handling that discards stale responses.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input logic              clk,
  input logic              rst_n,
  pc_fetch_unit_if.master  fetch_io
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    DROP  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_instr_q, if_instr_d;

  logic        req_valid;
  logic        req_fire;
  logic        buf_fire;
  logic [31:0] redirect_pc;

  assign redirect_pc = {fetch_io.pc_target[31:2], 2'b00};

  // rst_n gates the request so nothing is offered while reset is held.
  assign req_valid = rst_n && (state_q == FETCH) && !fetch_io.PCsrc &&
                     (!if_valid_q || fetch_io.if_ready);
  assign req_fire  = req_valid && fetch_io.imem_req_ready;
  assign buf_fire  = if_valid_q && fetch_io.if_ready;

  assign fetch_io.imem_req_valid = req_valid;
  assign fetch_io.imem_addr      = pc_q;
  assign fetch_io.if_valid       = if_valid_q;
  assign fetch_io.if_pc          = if_pc_q;
  assign fetch_io.if_instr       = if_instr_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_valid_d = if_valid_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;

    if (buf_fire) begin
      if_valid_d = 1'b0;
      if_instr_d = NOP_INSTR;
    end

    if (fetch_io.PCsrc) begin
      pc_d       = redirect_pc;
      if_valid_d = 1'b0;
      if_instr_d = NOP_INSTR;
      // An in-flight request left behind by a redirect must still be drained.
      case (state_q)
        FETCH:   state_d = FETCH;
        WAIT:    state_d = fetch_io.imem_rsp_valid ? FETCH : DROP;
        DROP:    state_d = fetch_io.imem_rsp_valid ? FETCH : DROP;
        default: state_d = FETCH;
      endcase
    end else begin
      case (state_q)
        FETCH: begin
          if (req_fire) state_d = WAIT;
        end
        WAIT: begin
          if (fetch_io.imem_rsp_valid) begin
            if_valid_d = 1'b1;
            if_pc_d    = pc_q;
            if_instr_d = fetch_io.imem_rsp_data;
            pc_d       = pc_q + 32'd4;
            state_d    = FETCH;
          end
        end
        DROP: begin
          if (fetch_io.imem_rsp_valid) state_d = FETCH;
        end
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      if_valid_q <= 1'b0;
      if_pc_q    <= 32'h0000_0000;
      if_instr_q <= NOP_INSTR;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_valid_q <= if_valid_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
    end
  end

endmodule
